// File: rtl/key_matrix_pkg.sv
// Shared types and helpers for the key matrix scanner.
package key_matrix_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        EVAL,
        GAP
    } scan_state_t;

    // Width of a key index for n_keys keys (at least one bit).
    function automatic int unsigned key_width(input int unsigned n_keys);
        int unsigned w;
        w = 1;
        if (n_keys > 1) w = $clog2(n_keys);
        return w;
    endfunction

    // Flat key index for row r, column c.
    function automatic int unsigned key_index(input int unsigned r,
                                              input int unsigned c,
                                              input int unsigned cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/key_event_slot.sv
// One-entry valid/ready holding register with a sticky overrun flag.
// A new item is accepted when the slot is empty or being drained this cycle;
// otherwise it is dropped and overrun latches.
module key_event_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overrun
);

    logic accept;
    logic drop;

    // Decide whether an incoming item fits in the slot.
    always_comb begin
        accept = in_valid && (!out_valid || out_ready);
        drop   = in_valid && out_valid && !out_ready;
    end

    // Slot contents, valid flag and sticky overrun.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// Scans a ROWS x COLS key matrix one row at a time, debounces every key and
// reports debounced changes as press/release events.
module key_matrix_scanner
    import key_matrix_pkg::*;
#(
    parameter int unsigned ROWS           = 4,
    parameter int unsigned COLS           = 4,
    parameter int unsigned SETTLE_CYCLES  = 480,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    localparam int unsigned KEY_W         = key_width(ROWS * COLS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [ROWS-1:0]      row_oe,
    input  logic [COLS-1:0]      col_in,
    output logic [ROWS*COLS-1:0] keys,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KEY_W-1:0]     evt_key,
    output logic                 evt_press,
    output logic                 overrun
);

    localparam int unsigned NKEYS = ROWS * COLS;
    localparam int unsigned ROW_W = key_width(ROWS);
    localparam int unsigned COL_W = key_width(COLS);
    localparam int unsigned CNT_W = key_width(SETTLE_CYCLES);

    scan_state_t      state, state_next;
    logic [ROW_W-1:0] row, row_next;
    logic [COL_W-1:0] col, col_next;
    logic [CNT_W-1:0] settle_cnt, settle_next;
    logic [ROWS-1:0]  row_oe_next;
    logic             snap_load;

    logic [COLS-1:0]  col_meta, col_sync, snap;
    logic [3:0]       db_cnt [NKEYS];

    logic [KEY_W-1:0] eval_key;
    logic             cur_state;
    logic             sample;
    logic             raise;
    logic [KEY_W:0]   slot_data;

    // Two-flop synchroniser; reset value means "all released".
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    // Scan state register; row_oe is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= DRIVE;
            row        <= '0;
            col        <= '0;
            settle_cnt <= '0;
            row_oe     <= '0;
            snap       <= '0;
        end else begin
            state      <= state_next;
            row        <= row_next;
            col        <= col_next;
            settle_cnt <= settle_next;
            row_oe     <= row_oe_next;
            if (snap_load) snap <= ~col_sync;
        end
    end

    // Next-state logic. The settle count holds while row_oe is still zero,
    // which only happens in the first cycle after reset, so every row gets
    // the full settle time with its output enable actually applied.
    always_comb begin
        state_next  = state;
        row_next    = row;
        col_next    = col;
        settle_next = settle_cnt;
        snap_load   = 1'b0;
        row_oe_next = '0;
        case (state)
            DRIVE: begin
                if (row_oe != '0) begin
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        snap_load   = 1'b1;
                        settle_next = '0;
                        col_next    = '0;
                        state_next  = EVAL;
                    end else begin
                        settle_next = settle_cnt + 1'b1;
                    end
                end
            end
            EVAL: begin
                if (col == COL_W'(COLS - 1)) begin
                    col_next   = '0;
                    state_next = GAP;
                end else begin
                    col_next = col + 1'b1;
                end
            end
            GAP: begin
                row_next   = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
                state_next = DRIVE;
            end
            default: state_next = DRIVE;
        endcase
        if (state_next != GAP) row_oe_next[row_next] = 1'b1;
    end

    // Select the key under evaluation and detect a debounced flip.
    always_comb begin
        eval_key  = KEY_W'(key_index(int'(row), int'(col), COLS));
        cur_state = keys[eval_key];
        sample    = snap[col];
        raise     = (state == EVAL) && (sample != cur_state)
                    && (db_cnt[eval_key] == 4'(DEBOUNCE_SCANS - 1));
        slot_data = {eval_key, ~cur_state};
    end

    // Per-key debounce counters and debounced key bitmap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned k = 0; k < NKEYS; k++) db_cnt[k] <= '0;
            keys <= '0;
        end else if (state == EVAL) begin
            if (sample == cur_state) begin
                db_cnt[eval_key] <= '0;
            end else if (raise) begin
                db_cnt[eval_key] <= '0;
                keys[eval_key]   <= ~cur_state;
            end else begin
                db_cnt[eval_key] <= db_cnt[eval_key] + 4'd1;
            end
        end
    end

    key_event_slot #(
        .DATA_W (KEY_W + 1)
    ) u_slot (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (raise),
        .in_data   (slot_data),
        .out_valid (evt_valid),
        .out_ready (evt_ready),
        .out_data  ({evt_key, evt_press}),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a key-matrix model and an
// event scoreboard.
module tb_key_matrix_scanner;

    logic        clk;
    logic        resetn;
    logic [3:0]  row_oe;
    logic [3:0]  col_in;
    logic [15:0] keys;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_key;
    logic        evt_press;
    logic        overrun;

    logic [15:0] pressed;

    typedef struct packed {
        logic [3:0] key;
        logic       press;
    } evt_t;

    evt_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    key_matrix_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .row_oe    (row_oe),
        .col_in    (col_in),
        .keys      (keys),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_press (evt_press),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Diode-isolated matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_in = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_oe[r] && pressed[r*4+c]) col_in[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int key, input logic press);
        evt_t e;
        e.key   = 4'(key);
        e.press = press;
        sb.push_back(e);
    endtask

    // Compare any handshake about to happen, then advance one cycle.
    task automatic tick();
        evt_t        e;
        logic [31:0] exp;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            exp = 32'hFFFF_FFFF;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                exp = {27'b0, e};
            end
            check("event", {27'b0, evt_key, evt_press}, exp);
        end
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        resetn    = 1'b0;
        evt_ready = 1'b1;
        pressed   = '0;
        @(negedge clk);
        step(3);
        check("rst_row_oe", row_oe, 0);
        check("rst_keys", keys, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_key", evt_key, 0);
        check("rst_evt_press", evt_press, 0);
        check("rst_overrun", overrun, 0);

        // Idle scan pattern: 8 cycles per row driven, 1 gap cycle.
        resetn = 1'b1;
        tick();
        for (int t = 0; t < 72; t++) begin
            check("idle_row_oe", row_oe,
                  ((t % 9) < 8) ? (32'd1 << ((t / 9) % 4)) : 32'd0);
            tick();
        end
        check("idle_keys", keys, 0);
        check("idle_no_events", sb.size(), 0);

        // Key 9 press then release.
        pressed[9] = 1'b1;
        push(9, 1'b1);
        step(72);
        check("k9_not_yet", keys, 0);
        step(36);
        check("k9_pressed", keys, 16'h0200);
        check("k9_press_evt", sb.size(), 0);
        pressed[9] = 1'b0;
        push(9, 1'b0);
        step(108);
        check("k9_released", keys, 0);
        check("k9_release_evt", sb.size(), 0);

        // Key 5 bounce: 2 closed, 1 open, 3 closed.
        pressed[5] = 1'b1;
        push(5, 1'b1);
        step(72);
        check("k5_two_scans", keys, 0);
        pressed[5] = 1'b0;
        step(36);
        pressed[5] = 1'b1;
        step(72);
        check("k5_after_bounce", keys, 0);
        step(36);
        check("k5_pressed", keys, 16'h0020);
        check("k5_one_event", sb.size(), 0);
        pressed[5] = 1'b0;
        push(5, 1'b0);
        step(108);
        check("k5_released", keys, 0);

        // Keys 12 and 13 flip in consecutive cycles: back-to-back load.
        pressed[12] = 1'b1;
        pressed[13] = 1'b1;
        push(12, 1'b1);
        push(13, 1'b1);
        step(108);
        check("b2b_keys", keys, 16'h3000);
        check("b2b_events", sb.size(), 0);
        check("b2b_no_overrun", overrun, 0);
        pressed[12] = 1'b0;
        pressed[13] = 1'b0;
        push(12, 1'b0);
        push(13, 1'b0);
        step(108);
        check("b2b_released", keys, 0);
        check("b2b_rel_events", sb.size(), 0);

        // Consumer stalled: key 0 held in slot, key 3 dropped.
        evt_ready  = 1'b0;
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        push(0, 1'b1);
        step(108);
        check("ovr_valid", evt_valid, 1);
        check("ovr_key", evt_key, 0);
        check("ovr_press", evt_press, 1);
        check("ovr_overrun", overrun, 1);
        check("ovr_keys", keys, 16'h0009);
        evt_ready = 1'b1;
        tick();
        check("ovr_drained", evt_valid, 0);
        check("ovr_sb", sb.size(), 0);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        push(0, 1'b0);
        push(3, 1'b0);
        step(107);
        check("ovr_released", keys, 0);
        check("ovr_rel_events", sb.size(), 0);
        check("ovr_sticky", overrun, 1);

        // Reset during EVAL of row 3 with an event pending.
        evt_ready   = 1'b0;
        pressed[12] = 1'b1;
        step(105);
        check("mid_pending", evt_valid, 1);
        check("mid_keys", keys, 16'h1000);
        resetn = 1'b0;
        tick();
        check("mid_rst_row_oe", row_oe, 0);
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_keys", keys, 0);
        check("mid_rst_overrun", overrun, 0);
        pressed   = '0;
        evt_ready = 1'b1;
        resetn    = 1'b1;
        tick();
        check("restart_row0", row_oe, 4'b0001);
        step(8);
        check("restart_gap", row_oe, 0);
        tick();
        check("restart_row1", row_oe, 4'b0010);
        step(20);
        check("final_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
Input-side counterpart of the LED matrix driver: scans a ROWS x COLS key/switch matrix on the doppler board instead of driving one. It pulls one row low at a time through SB_IO output-enables, samples the pulled-up column pins, debounces every key, and keeps a debounced key bitmap. Each debounced change is also emitted as a press/release event on a valid/ready handshake. It runs from the 48 MHz SB_HFOSC clock in top.

Parameters:
ROWS, 4, number of row lines driven (one-hot output-enable)
COLS, 4, number of column lines sampled
SETTLE_CYCLES, 480, clk cycles a row is driven before sampling (10 us at 48 MHz); must be >= 3
DEBOUNCE_SCANS, 4, consecutive disagreeing samples needed to flip a key; range 1..15

Ports:
clk  in  1  48 MHz system clock
resetn  in  1  synchronous reset, active low
row_oe  out  ROWS  1 = drive that row pin low (SB_IO OUTPUT_ENABLE, D_OUT_0 tied 0); 0 = high-Z
col_in  in  COLS  raw column pins, asynchronous, pulled up; 0 = key closed on driven row
keys  out  ROWS*COLS  debounced state, bit k = r*COLS+c, 1 = pressed
evt_valid  out  1  event slot holds an unconsumed event
evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready
evt_key  out  KEY_W  index k of the event key, KEY_W = clog2(ROWS*COLS)
evt_press  out  1  1 = press, 0 = release
overrun  out  1  sticky; an event was dropped because the slot was full

Behaviour:
- Interface is fixed: single clock clk; reset resetn is synchronous and active-low.
- On reset: row_oe=0, keys=0, evt_valid=0, evt_key=0, evt_press=0, overrun=0, all debounce counters=0, row=0, state=DRIVE, settle count=0.
- col_in passes through a 2-flop synchroniser. The synchroniser is cleared to all-ones on reset, meaning "released".
- FSM states:
  - DRIVE: row_oe = one-hot(row). Count SETTLE_CYCLES cycles. In the last cycle, latch snap = ~col_sync.
  - EVAL: row_oe stays asserted. Takes exactly COLS cycles, c = 0..COLS-1, and evaluates one key per cycle.
  - After EVAL with c = COLS-1, go to GAP.
  - GAP: 1 cycle with row_oe=0. row = (row+1) mod ROWS, wrapping ROWS-1 to 0. Then go to DRIVE.
- Timing: first row_oe[0]=1 appears the cycle after resetn is sampled high. One full scan takes ROWS*(SETTLE_CYCLES+COLS+1) cycles.
- Debounce for key k, evaluated in its EVAL cycle:
  - If snap[c] == keys[k], the counter is cleared to 0.
  - Otherwise the counter increments. On reaching DEBOUNCE_SCANS, keys[k] toggles, the counter clears, and an event {k, new state} is raised in the same cycle.
  - keys[k] changes the cycle after its EVAL cycle.
- Event slot, single entry:
  - A raised event loads the slot if evt_valid==0, or if evt_valid && evt_ready in the same cycle. evt_valid is 1 on the next cycle.
  - If evt_valid==1 and evt_ready==0 when an event is raised, the new event is dropped and overrun sets. The slot contents are unchanged. keys still updates.
  - A handshake with no new event clears evt_valid on the next cycle.
  - evt_key and evt_press are stable while evt_valid=1 and evt_ready=0.
- At most one event per cycle, by construction of the one-key-per-cycle EVAL.
- overrun clears only on reset.
- Reset mid-scan: immediate return to the reset state. row_oe goes 0 the next cycle; any pending event is lost.
- Ghosting is not resolved; the matrix is assumed diode-isolated.

Decomposition:
- Package key_matrix_pkg holds:
  - the state enum {DRIVE, EVAL, GAP};
  - the KEY_W function or constant;
  - the key index helper r*COLS+c.
- Sub-module key_event_slot: the one-entry valid/ready holding register with overrun. This part is reused by future UART and encoder readers.
- Debounce counters stay inline as a ROWS*COLS x 4-bit register array.

Test Plan:
Bench parameters: ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3; evt_ready=1 unless stated.
1. Reset then idle with all col_in=1 -> row_oe cycles 0001,0010,0100,1000,0001 with a 0000 gap between rows; scan period 36 cycles; keys=0; no events.
2. Hold key r=2,c=1 closed (col_in[1]=0 whenever row_oe[2]=1) -> after the 3rd scan sample, keys[9]=1 and one event {evt_key=9, evt_press=1}. Releasing for 3 scans gives one event {9, 0}.
3. Bounce on key 5 (closed 2 scans, open 1, closed 3) -> exactly one press event, issued on the 6th scan; no release event.
4. evt_ready=0 with keys 0 and 3 pressed together -> slot holds {0,1}; key 3's event is dropped; overrun=1; keys[3]=1 anyway. Raising evt_ready then gives one handshake and evt_valid=0.
5. Event raised in the same cycle as an evt_valid&&evt_ready handshake -> new event loaded back-to-back with no overrun.
6. Assert resetn=0 during EVAL of row 3 with a pending event -> next cycle row_oe=0, evt_valid=0, keys=0, overrun=0; scanning restarts at row 0.
